// File: rtl/attendance_capture_if.sv
// Record handshake bundle between attendance_capture and its consumer.
// One record (attendance + late) is offered while rec_valid is high.
// The consumer stalls the producer by holding rec_ready low.
interface attendance_capture_if;
  logic rec_valid;
  logic rec_ready;
  logic attendance;
  logic late;

  modport master (output rec_valid, output attendance, output late, input rec_ready);
  modport slave  (input rec_valid, input attendance, input late, output rec_ready);
endinterface

// File: rtl/attendance_capture.sv
// Purpose: debounce a raw present button and emit one attendance record per class session.
// Latency: mark event 2+DEBOUNCE_CYCLES edges after mark_in settles; record valid 1 cycle after class_end.
// Backpressure: record held stable in EMIT until rec_ready; optional macro ATT_LATE_AS_PRESENT_EN counts late marks as present.
module attendance_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LATE_LIMIT      = 8,
  parameter int MAX_CLASSES     = 100   // must fit in class_count (<= 127)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 class_start,
  input  logic                 class_end,
  input  logic                 mark_in,
  attendance_capture_if.master rec,
  output logic                 in_session,
  output logic [6:0]           class_count,
  output logic                 sem_over
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WIN_W = $clog2(LATE_LIMIT + 1);

`ifdef ATT_LATE_AS_PRESENT_EN
  localparam bit LATE_PRESENT = 1'b1;
`else
  localparam bit LATE_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_LATE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state;
  logic              sync1;
  logic              sync2;
  logic [DB_W-1:0]   db_cnt;
  logic              db_level;
  logic              db_prev;
  logic [WIN_W-1:0]  win_cnt;
  logic              present_r;
  logic              late_r;
  logic              mark_evt;
  logic              mark_take;

  // Rising edge of the debounced level is the mark event.
  assign mark_evt  = db_level & ~db_prev;
  // Only the first mark of a session is recorded; later ones are ignored.
  assign mark_take = mark_evt & ~(present_r | late_r);

  // Synchronize the raw button, then accept a level change only after DEBOUNCE_CYCLES
  // consecutive synchronized samples disagree with the current level.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      sync1   <= mark_in;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Session FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= S_IDLE;
      present_r      <= 1'b0;
      late_r         <= 1'b0;
      win_cnt        <= '0;
      rec.rec_valid  <= 1'b0;
      rec.attendance <= 1'b0;
      rec.late       <= 1'b0;
      in_session     <= 1'b0;
      class_count    <= '0;
      sem_over       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          present_r <= 1'b0;
          late_r    <= 1'b0;
          win_cnt   <= '0;
          // A simultaneous class_end is ignored here: start wins.
          if (class_start) begin
            state      <= S_OPEN;
            in_session <= 1'b1;
          end
        end

        S_OPEN: begin
          win_cnt <= win_cnt + WIN_W'(1);
          if (mark_take) present_r <= 1'b1;
          // End has priority over the window expiring in the same cycle.
          if (class_end) begin
            state          <= S_EMIT;
            in_session     <= 1'b0;
            rec.rec_valid  <= 1'b1;
            rec.attendance <= present_r | mark_take;
            rec.late       <= late_r;
          end else if (win_cnt == WIN_W'(LATE_LIMIT - 1)) begin
            state <= S_LATE;
          end
        end

        S_LATE: begin
          if (mark_take) begin
            late_r <= 1'b1;
            if (LATE_PRESENT) present_r <= 1'b1;
          end
          if (class_end) begin
            state          <= S_EMIT;
            in_session     <= 1'b0;
            rec.rec_valid  <= 1'b1;
            rec.attendance <= present_r | (mark_take & LATE_PRESENT);
            rec.late       <= late_r | mark_take;
          end
        end

        S_EMIT: begin
          // Record stays put until the consumer takes it.
          if (rec.rec_ready) begin
            rec.rec_valid  <= 1'b0;
            rec.attendance <= 1'b0;
            rec.late       <= 1'b0;
            class_count    <= class_count + 7'd1;
            if (class_count + 7'd1 == 7'(MAX_CLASSES)) begin
              state    <= S_DONE;
              sem_over <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_DONE: begin
          // Semester complete: hold everything until clr.
          state <= S_DONE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attendance_capture.sv
// Randomized bench for attendance_capture with a session-level reference model.
// Model tracks debounced marks by sliding-window rule and session timing by edge arithmetic.
// Expected records are queued at class_end; a negedge monitor compares every cycle.
module tb_attendance_capture;
  localparam int DB = 4;
  localparam int LL = 8;
  localparam int MC = 3;
`ifdef ATT_LATE_AS_PRESENT_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       class_start;
  logic       class_end;
  logic       mark_in;
  logic       in_session;
  logic [6:0] class_count;
  logic       sem_over;

  attendance_capture_if rif();

  attendance_capture #(
    .DEBOUNCE_CYCLES(DB),
    .LATE_LIMIT     (LL),
    .MAX_CLASSES    (MC)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .class_start(class_start),
    .class_end  (class_end),
    .mark_in    (mark_in),
    .rec        (rif.master),
    .in_session (in_session),
    .class_count(class_count),
    .sem_over   (sem_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic att;
    logic lt;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (session level, not FSM level)
  int   edge_no   = 0;
  bit   lvl_cur   = 1'b0;
  bit   lvl_old   = 1'b0;
  bit   raw_q[$];
  bit   in_sess_m = 1'b0;
  int   sess_start = 0;
  bit   marked, m_ontime, m_late;
  bit   pend_m    = 1'b0;
  int   cnt_m     = 0;
  bit   done_m    = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model, evaluated at every rising edge from the inputs the DUT sees.
  initial begin
    for (int i = 0; i < DB + 2; i++) raw_q.push_back(1'b0);
    forever begin
      @(posedge clk);
      begin
        bit evt;
        bit flip;
        edge_no++;
        evt = lvl_cur & ~lvl_old;
        raw_q.push_back(mark_in);
        void'(raw_q.pop_front());
        // Level changes once DB consecutive samples (2-edge sync delay) differ from it.
        flip = 1'b1;
        for (int i = 0; i < DB; i++) if (raw_q[i] == lvl_cur) flip = 1'b0;
        lvl_old = lvl_cur;
        if (flip) lvl_cur = ~lvl_cur;

        if (clr) begin
          raw_q[DB]     = 1'b0;
          raw_q[DB + 1] = 1'b0;
          lvl_cur   = 1'b0;
          lvl_old   = 1'b0;
          if (pend_m) void'(exp_q.pop_back());
          in_sess_m = 1'b0;
          pend_m    = 1'b0;
          cnt_m     = 0;
          done_m    = 1'b0;
        end else if (done_m) begin
          done_m = 1'b1;
        end else if (pend_m) begin
          if (rif.rec_ready) begin
            pend_m = 1'b0;
            cnt_m++;
            if (cnt_m == MC) done_m = 1'b1;
          end
        end else if (in_sess_m) begin
          if (evt && !marked) begin
            marked = 1'b1;
            if (edge_no - sess_start <= LL) m_ontime = 1'b1;
            else m_late = 1'b1;
          end
          if (class_end) begin
            in_sess_m = 1'b0;
            pend_m    = 1'b1;
            exp_q.push_back('{att: m_ontime | (m_late & LP), lt: m_late});
          end
        end else if (class_start) begin
          in_sess_m  = 1'b1;
          sess_start = edge_no;
          marked     = 1'b0;
          m_ontime   = 1'b0;
          m_late     = 1'b0;
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (edge_no > 0) begin
        check("rec_valid", 32'(rif.rec_valid), 32'(pend_m));
        check("in_session", 32'(in_session), 32'(in_sess_m));
        check("class_count", 32'(class_count), 32'(cnt_m));
        check("sem_over", 32'(sem_over), 32'(done_m));
        if (rif.rec_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("record_expected", 32'(0), 32'(1));
          end else begin
            check("attendance", 32'(rif.attendance), 32'(exp_q[0].att));
            check("late", 32'(rif.late), 32'(exp_q[0].lt));
            if (rif.rec_ready && !clr) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // One class scenario: c=0 is the class_start edge.
  // kind: 0 none, 1 clean press, 2 bouncing 3-high/2-low, 3 short glitch.
  task automatic scenario(input int end_off, input int kind, input int moff, input int mlen,
                          input int stall, input int clr_at, input bit both);
    int total;
    total = end_off + stall + 10;
    for (int c = 0; c < total; c++) begin
      class_start = (c == 0) || (c > 0 && c <= end_off + stall && $urandom_range(0, 7) == 0);
      class_end   = (c == end_off) || (c == 0 && both);
      case (kind)
        1:       mark_in = (c >= moff) && (c < moff + mlen) && (c <= end_off + 2);
        2:       mark_in = (c >= moff) && (c <= end_off) && (((c - moff) % 5) < 3);
        3:       mark_in = (c >= moff) && (c < moff + mlen);
        default: mark_in = 1'b0;
      endcase
      if (c > end_off + stall)  rif.rec_ready = 1'b1;
      else if (c <= end_off)    rif.rec_ready = 1'($urandom_range(0, 1));
      else                      rif.rec_ready = 1'b0;
      clr = (c == clr_at);
      @(posedge clk);
      #1;
    end
    class_start = 1'b0;
    class_end   = 1'b0;
    mark_in     = 1'b0;
    clr         = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    class_start = 1'b0;
    class_end = 1'b0;
    mark_in = 1'b0;
    rif.rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // On-time mark, bounce rejection, late mark (third class ends the semester)
    scenario(20, 1, 1, 10, 0, -1, 1'b0);
    scenario(20, 2, 1, 0, 0, -1, 1'b0);
    scenario(20, 1, 10, 8, 0, -1, 1'b0);
    // Semester over: this class must be ignored, then clear
    scenario(12, 1, 1, 8, 0, 21, 1'b0);
    // Backpressure with ignored starts during the stall
    scenario(14, 1, 3, 8, 5, -1, 1'b0);
    // Mid-session clear in LATE after a captured mark
    scenario(20, 1, 5, 8, 0, 13, 1'b0);
    // Start and end together, then close normally
    scenario(15, 1, 2, 6, 2, -1, 1'b1);

    for (int s = 0; s < 150; s++) begin
      int e, k, mo, ml, st, ca;
      bit bo;
      e  = $urandom_range(2, 24);
      k  = $urandom_range(0, 3);
      mo = $urandom_range(1, 20);
      ml = (k == 3) ? $urandom_range(1, DB - 1) : $urandom_range(5, 12);
      st = $urandom_range(0, 5);
      bo = ($urandom_range(0, 7) == 0);
      ca = -1;
      if (done_m) ca = e + st + 9;
      else if ($urandom_range(0, 9) == 0) ca = $urandom_range(1, e);
      scenario(e, k, mo, ml, st, ca, bo);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
